// File: rtl/uart_rx_framed.sv
// uart_rx_framed
//   UART receiver that assembles W_OUT/BITS_PER_WORD serial words (LSB first)
//   into one packet. It supports none/even/odd parity, one or two stop bits,
//   and a multi-flop input synchroniser. Parity and framing errors are
//   accumulated per packet. The packet is presented on a valid/ready
//   handshake, and a packet that completes while the output is still
//   occupied is dropped and reported on overrun.
//
// Ports
//   clk          : clock, all logic on the rising edge
//   rst          : synchronous active-high reset
//   rx           : asynchronous serial input, idle high
//   m_ready      : downstream accepts the held packet
//   m_valid      : a packet is held in m_data
//   m_data       : assembled packet, first word in [BITS_PER_WORD-1:0]
//   m_parity_err : some word of the held packet failed parity
//   m_frame_err  : some stop bit of the held packet sampled low
//   overrun      : one-cycle pulse when a completed packet is discarded
module uart_rx_framed #(
    parameter int CLOCKS_PER_PULSE = 4,
    parameter int BITS_PER_WORD    = 8,
    parameter int W_OUT            = 16,
    parameter int PARITY_MODE      = 1,
    parameter int STOP_BITS        = 1,
    parameter int SYNC_STAGES      = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx,
    input  logic             m_ready,
    output logic             m_valid,
    output logic [W_OUT-1:0] m_data,
    output logic             m_parity_err,
    output logic             m_frame_err,
    output logic             overrun
);

    localparam int NUM_WORDS = W_OUT / BITS_PER_WORD;
    localparam int CW = (CLOCKS_PER_PULSE > 1) ? $clog2(CLOCKS_PER_PULSE) : 1;
    localparam int BW = (BITS_PER_WORD > 1) ? $clog2(BITS_PER_WORD) : 1;
    localparam int SW = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;
    localparam int WW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    localparam logic [CW-1:0] CLK_LAST  = CW'(CLOCKS_PER_PULSE - 1);
    localparam logic [CW-1:0] CLK_HALF  = CW'(CLOCKS_PER_PULSE / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(BITS_PER_WORD - 1);
    localparam logic [SW-1:0] STOP_LAST = SW'(STOP_BITS - 1);
    localparam logic [WW-1:0] WORD_LAST = WW'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;

    logic [CW-1:0]    clk_cnt_q,  clk_cnt_d;
    logic [BW-1:0]    bit_cnt_q,  bit_cnt_d;
    logic [SW-1:0]    stop_cnt_q, stop_cnt_d;
    logic [WW-1:0]    word_cnt_q, word_cnt_d;
    logic [W_OUT-1:0] asm_q,      asm_d;
    logic             xor_q,      xor_d;
    logic             perr_q,     perr_d;
    logic             ferr_q,     ferr_d;
    logic             mvalid_q,   mvalid_d;
    logic [W_OUT-1:0] mdata_q,    mdata_d;
    logic             mperr_q,    mperr_d;
    logic             mferr_q,    mferr_d;
    logic             ovr_q,      ovr_d;

    // Decoded strobes produced by the FSM output process
    logic sample_pt, half_pt, start_ok, data_smp, last_bit;
    logic par_smp, par_exp, stop_smp, last_stop, pkt_done;

    assign rx_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (!rx_s) state_d = S_START;
            S_START:     if (half_pt) state_d = rx_s ? S_IDLE : S_DATA;
            S_DATA:      if (data_smp && last_bit)
                             state_d = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
            S_PARITY:    if (sample_pt) state_d = S_STOP;
            // A low final stop bit means a break or stuck line; wait for idle
            // so the low level is not taken as the next start bit.
            S_STOP:      if (last_stop) state_d = rx_s ? S_IDLE : S_WAIT_IDLE;
            S_WAIT_IDLE: if (rx_s) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // FSM: output decode
    always_comb begin
        sample_pt = (clk_cnt_q == CLK_LAST);
        half_pt   = (clk_cnt_q == CLK_HALF);
        start_ok  = (state_q == S_START) && half_pt && !rx_s;
        data_smp  = (state_q == S_DATA) && sample_pt;
        last_bit  = (bit_cnt_q == BIT_LAST);
        par_smp   = (state_q == S_PARITY) && sample_pt;
        par_exp   = (PARITY_MODE == 2) ? ~xor_q : xor_q;
        stop_smp  = (state_q == S_STOP) && sample_pt;
        last_stop = stop_smp && (stop_cnt_q == STOP_LAST);
        pkt_done  = last_stop && (word_cnt_q == WORD_LAST);
    end

    // Datapath next state
    always_comb begin
        clk_cnt_d  = clk_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        word_cnt_d = word_cnt_q;
        asm_d      = asm_q;
        xor_d      = xor_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        mvalid_d   = mvalid_q;
        mdata_d    = mdata_q;
        mperr_d    = mperr_q;
        mferr_d    = mferr_q;
        ovr_d      = 1'b0;

        case (state_q)
            S_START:                  clk_cnt_d = half_pt ? '0 : clk_cnt_q + 1'b1;
            S_DATA, S_PARITY, S_STOP: clk_cnt_d = sample_pt ? '0 : clk_cnt_q + 1'b1;
            default:                  clk_cnt_d = '0;
        endcase

        if (start_ok) begin
            xor_d = 1'b0;
            if (word_cnt_q == '0) begin
                perr_d = 1'b0;
                ferr_d = 1'b0;
            end
        end

        if (data_smp) begin
            asm_d     = {rx_s, asm_q[W_OUT-1:1]};
            xor_d     = xor_q ^ rx_s;
            bit_cnt_d = last_bit ? '0 : bit_cnt_q + 1'b1;
        end

        if (par_smp && (rx_s != par_exp)) begin
            perr_d = 1'b1;
        end

        if (stop_smp) begin
            if (!rx_s) ferr_d = 1'b1;
            stop_cnt_d = last_stop ? '0 : stop_cnt_q + 1'b1;
            if (last_stop) word_cnt_d = pkt_done ? '0 : word_cnt_q + 1'b1;
        end

        if (mvalid_q && m_ready) begin
            mvalid_d = 1'b0;
        end

        // ferr_d already includes the stop bit sampled in this cycle
        if (pkt_done) begin
            if (!mvalid_q || m_ready) begin
                mvalid_d = 1'b1;
                mdata_d  = asm_q;
                mperr_d  = perr_q;
                mferr_d  = ferr_d;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= '0;
            word_cnt_q <= '0;
            asm_q      <= '0;
            xor_q      <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            mvalid_q   <= 1'b0;
            mdata_q    <= '0;
            mperr_q    <= 1'b0;
            mferr_q    <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            clk_cnt_q  <= clk_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            word_cnt_q <= word_cnt_d;
            asm_q      <= asm_d;
            xor_q      <= xor_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            mvalid_q   <= mvalid_d;
            mdata_q    <= mdata_d;
            mperr_q    <= mperr_d;
            mferr_q    <= mferr_d;
            ovr_q      <= ovr_d;
        end
    end

    assign m_valid      = mvalid_q;
    assign m_data       = mdata_q;
    assign m_parity_err = mperr_q;
    assign m_frame_err  = mferr_q;
    assign overrun      = ovr_q;

endmodule

// File: tb/tb_uart_rx_framed.sv
// Bench for uart_rx_framed with default configuration (4 clocks/bit, 8-bit
// words, 16-bit packets, even parity, one stop bit). Expected packets are
// queued when their words are sent and compared at each handshake.
module tb_uart_rx_framed;

    localparam int CPP = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx = 1'b1;
    logic        m_ready = 1'b1;
    logic        m_valid;
    logic [15:0] m_data;
    logic        m_parity_err;
    logic        m_frame_err;
    logic        overrun;

    uart_rx_framed #(
        .CLOCKS_PER_PULSE(CPP),
        .BITS_PER_WORD(8),
        .W_OUT(16),
        .PARITY_MODE(1),
        .STOP_BITS(1),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .m_ready(m_ready),
        .m_valid(m_valid),
        .m_data(m_data),
        .m_parity_err(m_parity_err),
        .m_frame_err(m_frame_err),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic        pe;
        logic        fe;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail = 0;
    int   ovr_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard side: compare every accepted packet against the queue head
    always @(negedge clk) begin
        if (!rst) begin
            if (overrun) ovr_cnt++;
            if (m_valid && m_ready) begin
                chk("pkt_expected", 32'(sb.size() != 0), 32'(1));
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    chk("m_data", 32'(m_data), 32'(mon_e.d));
                    chk("m_parity_err", 32'(m_parity_err), 32'(mon_e.pe));
                    chk("m_frame_err", 32'(m_frame_err), 32'(mon_e.fe));
                end
            end
        end
    end

    task automatic drive(input logic b, input int n);
        rx = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Start, 8 data bits LSB first, even parity (optionally flipped), stop
    task automatic send_word(input logic [7:0] d, input logic par_flip, input logic stop_v);
        drive(1'b0, CPP);
        for (int i = 0; i < 8; i++) drive(d[i], CPP);
        drive((^d) ^ par_flip, CPP);
        drive(stop_v, CPP);
    endtask

    task automatic push_pkt(input logic [7:0] w0, input logic [7:0] w1,
                            input logic pe, input logic fe);
        exp_t e;
        e.d  = {w1, w0};
        e.pe = pe;
        e.fe = fe;
        sb.push_back(e);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        chk("drain", 32'(sb.size()), 32'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_m_valid", 32'(m_valid), 32'(0));
        chk("rst_m_data", 32'(m_data), 32'(0));
        chk("rst_perr", 32'(m_parity_err), 32'(0));
        chk("rst_ferr", 32'(m_frame_err), 32'(0));
        chk("rst_overrun", 32'(overrun), 32'(0));
        @(posedge clk);
        #1;
        drive(1'b1, 8);

        // Clean packet
        push_pkt(8'hA5, 8'h3C, 1'b0, 1'b0);
        send_word(8'hA5, 1'b0, 1'b1);
        send_word(8'h3C, 1'b0, 1'b1);
        drive(1'b1, 4);
        wait_drain();
        chk("overrun_clean", 32'(ovr_cnt), 32'(0));

        // Parity error on the second word, then a clean packet clears it
        push_pkt(8'hA5, 8'h3C, 1'b1, 1'b0);
        send_word(8'hA5, 1'b0, 1'b1);
        send_word(8'h3C, 1'b1, 1'b1);
        drive(1'b1, 4);
        wait_drain();
        push_pkt(8'hA5, 8'h3C, 1'b0, 1'b0);
        send_word(8'hA5, 1'b0, 1'b1);
        send_word(8'h3C, 1'b0, 1'b1);
        drive(1'b1, 4);
        wait_drain();

        // Framing error: low stop bit followed by a long low line
        push_pkt(8'hA5, 8'h3C, 1'b0, 1'b1);
        send_word(8'hA5, 1'b0, 1'b0);
        drive(1'b0, 20);
        drive(1'b1, 8);
        send_word(8'h3C, 1'b0, 1'b1);
        drive(1'b1, 4);
        wait_drain();

        // One-cycle glitch must not start a word
        drive(1'b1, 8);
        drive(1'b0, 1);
        drive(1'b1, 20);
        chk("glitch_no_valid", 32'(m_valid), 32'(0));
        push_pkt(8'h11, 8'h22, 1'b0, 1'b0);
        send_word(8'h11, 1'b0, 1'b1);
        send_word(8'h22, 1'b0, 1'b1);
        drive(1'b1, 4);
        wait_drain();

        // Backpressure: second packet completes while first is held
        m_ready = 1'b0;
        push_pkt(8'h02, 8'h01, 1'b0, 1'b0);
        send_word(8'h02, 1'b0, 1'b1);
        send_word(8'h01, 1'b0, 1'b1);
        send_word(8'h04, 1'b0, 1'b1);
        send_word(8'h03, 1'b0, 1'b1);
        drive(1'b1, 8);
        chk("bp_valid_held", 32'(m_valid), 32'(1));
        chk("bp_data_held", 32'(m_data), 32'(16'h0102));
        chk("bp_overrun_once", 32'(ovr_cnt), 32'(1));
        m_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_valid_drop", 32'(m_valid), 32'(0));
        chk("bp_sb_empty", 32'(sb.size()), 32'(0));
        @(posedge clk);
        #1;

        // Reset in the middle of word 0
        drive(1'b0, CPP);
        drive(1'b1, CPP);
        drive(1'b0, CPP);
        drive(1'b1, CPP);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rx  = 1'b1;
        chk("mid_rst_m_valid", 32'(m_valid), 32'(0));
        chk("mid_rst_m_data", 32'(m_data), 32'(0));
        chk("mid_rst_perr", 32'(m_parity_err), 32'(0));
        chk("mid_rst_ferr", 32'(m_frame_err), 32'(0));
        chk("mid_rst_overrun", 32'(overrun), 32'(0));
        drive(1'b1, 8);
        push_pkt(8'hEF, 8'hBE, 1'b0, 1'b0);
        send_word(8'hEF, 1'b0, 1'b1);
        send_word(8'hBE, 1'b0, 1'b1);
        drive(1'b1, 4);
        wait_drain();

        chk("overrun_total", 32'(ovr_cnt), 32'(1));
        chk("sb_empty_end", 32'(sb.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/uart_rx_framed.md
# uart_rx_framed

Parametrised UART receiver that assembles `W_OUT/BITS_PER_WORD` serial words into one output packet, with selectable parity (none/even/odd), one or two stop bits, and an input synchroniser. Start bits are glitch-rejected; parity and framing errors are flagged rather than silently dropped. The packet is delivered over a valid/ready handshake with overrun reporting. It is the next-generation front end for serial-loaded data buses in the FPGA designs.

## Interface
- `CLOCKS_PER_PULSE`, 4: clocks per bit period; even, ≥4.
- `BITS_PER_WORD`, 8: data bits per serial word.
- `W_OUT`, 16: packet width; integer multiple of `BITS_PER_WORD`.
- `PARITY_MODE`, 1: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: 1 or 2.
- `SYNC_STAGES`, 2: `rx` synchroniser depth, ≥2.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `rx` in 1: asynchronous serial line, idle high.
- `m_ready` in 1: downstream accepts the packet.
- `m_valid` out 1: packet held in `m_data`.
- `m_data` out `W_OUT`: assembled packet. The first word received is in `[BITS_PER_WORD-1:0]`.
- `m_parity_err` out 1: at least one word in this packet failed parity. Qualified by `m_valid`.
- `m_frame_err` out 1: at least one stop bit in this packet sampled low. Qualified by `m_valid`.
- `overrun` out 1: one-cycle pulse when a completed packet is discarded.

## Operation
- **Reset:** `m_valid`, `m_data`, both error flags, `overrun`, and all counters are 0. Synchroniser flops are 1. State is IDLE.
- **Synchroniser:** `rx_s` is `rx` delayed by `SYNC_STAGES` flops. All decisions use `rx_s`.
- **Counters:**
  - `c_clocks`: 0..`CLOCKS_PER_PULSE-1`.
  - `c_bits`: 0..`BITS_PER_WORD-1`.
  - `c_stop`: 0..`STOP_BITS-1`.
  - `c_words`: 0..`NUM_WORDS-1`.
  - Widths are `$clog2` of each range, minimum 1.
- **States:**
  - IDLE: on `rx_s==0`, go to START with `c_clocks=0`.
  - START: at `c_clocks==CLOCKS_PER_PULSE/2-1`, if `rx_s==0` go to DATA, otherwise go to IDLE (false start; nothing recorded). `c_clocks` is cleared on either exit.
  - DATA: at `c_clocks==CLOCKS_PER_PULSE-1`, sample `rx_s` LSB-first into the assembly register, shifting in at the MSB: `asm <= {rx_s, asm[W_OUT-1:1]}`. A running XOR accumulates the current word. After bit `BITS_PER_WORD-1`, go to PARITY if `PARITY_MODE!=0`, else to STOP.
  - PARITY: sample at `CLOCKS_PER_PULSE-1`. Expected bit is XOR for even mode and ~XOR for odd mode. A mismatch sets the packet parity flag. Always continue to STOP; the word is never aborted.
  - STOP: sample each stop bit at `CLOCKS_PER_PULSE-1`. If `rx_s==0`, set the packet frame flag. After the last stop bit:
    - a low sample goes to WAIT_IDLE;
    - otherwise go to IDLE.
    - If `c_words==NUM_WORDS-1`, complete the packet and clear `c_words`; else increment `c_words`.
  - WAIT_IDLE: hold until `rx_s==1`, then go to IDLE. This covers a break or stuck-low line so no false start occurs.
- **Error flags:** the packet's internal flags clear when word 0 enters DATA.
- **Packet completion:**
  - If `!m_valid || m_ready` in the completion cycle, load `m_data`, both error flags, and `m_valid=1`.
  - Otherwise discard the packet, pulse `overrun`, and leave the held outputs unchanged.
- **Handshake:** `m_valid` falls on the cycle after `m_valid && m_ready` unless a new packet loads in that same cycle, in which case it stays 1. `m_data` and the flags are stable while `m_valid && !m_ready`.
- **Reset mid-operation:** any state returns to IDLE, the partial packet is lost, and outputs return to reset values.

## Timing
- Bit sample point: `CLOCKS_PER_PULSE/2` cycles after the detected falling edge, then every `CLOCKS_PER_PULSE` cycles.
- Start to first sample: `SYNC_STAGES` cycles of synchroniser delay on top of that.
- Word length: `(1 + BITS_PER_WORD + (PARITY_MODE!=0) + STOP_BITS) × CLOCKS_PER_PULSE` cycles.
- `m_valid` rises one cycle after the edge that samples the final stop bit of the last word.
- `overrun` is high for exactly one cycle.
- Back-to-back words are accepted: IDLE is reached mid-stop-bit, so the next start edge is caught. No dead time beyond half a bit.

## Test plan
Defaults throughout: `CLOCKS_PER_PULSE=4`, `BITS_PER_WORD=8`, `W_OUT=16`, even parity, 1 stop bit.
- **Clean packet:** send 0xA5 then 0x3C (parity 0, 0) with `m_ready=1` → `m_data=0x3CA5`, `m_valid` high 1 cycle, both error flags 0, `overrun` 0.
- **Parity error:** same words, parity bit 1 on 0x3C → `m_data=0x3CA5`, `m_parity_err=1`, `m_frame_err=0`. The next clean packet reports `m_parity_err=0`.
- **Framing error:** stop bit of 0xA5 driven 0 with `rx` held low 20 cycles, then a clean 0x3C → no spurious start while low, packet `0x3CA5`, `m_frame_err=1`.
- **Glitch rejection:** `rx` low for 1 cycle after synchroniser settling → state returns to IDLE, no `m_valid`. A following 0x11, 0x22 yields `0x2211`.
- **Backpressure:** `m_ready=0`, send 0x0102 then 0x0304 → `m_data=0x0102` held, `overrun` pulses once at the second completion. Raising `m_ready` drops `m_valid` the next cycle.
- **Reset mid-packet:** `rst` for 1 cycle during DATA of word 0 → all outputs 0. A following clean 0xBEEF is received as `0xBEEF`.
